// File: rtl/snoopy_vertical_physics.sv
// Vertical motion controller for Snoopy: signed velocity, gravity per frame
// tick, multi-jump chaining, ceiling head-bump, terminal fall velocity and a
// runtime floor height. Position is unsigned screen Y (down = positive).
//
// Jump handshake: jump_in is a synchronised level. Each rising edge raises a
// single buffered request. Every frame_tick clears that request, whether or
// not the tick consumes it. An edge that arrives on the tick's own clock is
// seen by that tick.
module snoopy_vertical_physics #(
    parameter int Y_WIDTH      = 7,
    parameter int V_WIDTH      = 6,
    parameter int GROUND_Y     = 100,
    parameter int CEILING_Y    = 0,
    parameter int JUMP_VEL     = 8,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL_VEL = 10,
    parameter int MAX_JUMPS    = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               frame_tick,
    input  logic                               jump_in,
    input  logic [Y_WIDTH-1:0]                 floor_y,
    output logic [Y_WIDTH-1:0]                 snoopy_y,
    output logic [V_WIDTH-1:0]                 vel_y,
    output logic [1:0]                         state_out,
    output logic [$clog2(MAX_JUMPS+1)-1:0]     jumps_used,
    output logic                               on_ground,
    output logic                               landed
);

    localparam int J_WIDTH = $clog2(MAX_JUMPS + 1);
    // Two extra bits give headroom above the screen range and a sign bit.
    localparam int S_WIDTH = Y_WIDTH + 2;

    localparam logic signed [S_WIDTH-1:0] JUMP_S = S_WIDTH'(JUMP_VEL);
    localparam logic signed [S_WIDTH-1:0] GRAV_S = S_WIDTH'(GRAVITY);
    localparam logic signed [S_WIDTH-1:0] MAXF_S = S_WIDTH'(MAX_FALL_VEL);
    localparam logic signed [S_WIDTH-1:0] CEIL_S = S_WIDTH'(CEILING_Y);
    localparam logic [Y_WIDTH-1:0]        CEIL_Y = Y_WIDTH'(CEILING_Y);
    localparam logic [Y_WIDTH-1:0]        RST_Y  = Y_WIDTH'(GROUND_Y);
    localparam logic [J_WIDTH-1:0]        MAX_J  = J_WIDTH'(MAX_JUMPS);

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_RISE   = 2'b01,
        ST_FALL   = 2'b10
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 jump_prev;
    logic                 jump_req;
    logic                 jump_edge;
    logic                 req_now;
    logic                 can_rejump;
    logic                 land_now;
    logic [Y_WIDTH-1:0]   next_y;
    logic [V_WIDTH-1:0]   next_vel;
    logic [J_WIDTH-1:0]   next_jumps;
    logic signed [S_WIDTH-1:0] y_s;
    logic signed [S_WIDTH-1:0] vel_s;
    logic signed [S_WIDTH-1:0] floor_s;
    logic signed [S_WIDTH-1:0] y_try;
    logic signed [S_WIDTH-1:0] vel_try;

    assign jump_edge  = jump_in & ~jump_prev;
    assign req_now    = jump_req | jump_edge;
    assign can_rejump = req_now && (jumps_used < MAX_J);
    assign y_s        = {2'b00, snoopy_y};
    assign floor_s    = {2'b00, floor_y};
    assign vel_s      = {{(S_WIDTH - V_WIDTH){vel_y[V_WIDTH-1]}}, vel_y};

    // State and datapath registers; everything only moves on frame_tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_GROUND;
            snoopy_y   <= RST_Y;
            vel_y      <= '0;
            jumps_used <= '0;
            landed     <= 1'b0;
            jump_prev  <= 1'b0;
            jump_req   <= 1'b0;
        end else begin
            state      <= next_state;
            snoopy_y   <= next_y;
            vel_y      <= next_vel;
            jumps_used <= next_jumps;
            landed     <= land_now;
            jump_prev  <= jump_in;
            if (frame_tick) begin
                jump_req <= 1'b0;
            end else if (jump_edge) begin
                jump_req <= 1'b1;
            end
        end
    end

    // Next-state and physics step: semi-implicit, new y = y + new velocity.
    always_comb begin
        next_state = state;
        next_y     = snoopy_y;
        next_vel   = vel_y;
        next_jumps = jumps_used;
        land_now   = 1'b0;
        y_try      = y_s;
        vel_try    = vel_s;
        if (frame_tick) begin
            case (state)
                ST_GROUND: begin
                    if (req_now) begin
                        y_try      = y_s - JUMP_S;
                        next_vel   = vel_try[V_WIDTH-1:0];
                        next_vel   = V_WIDTH'(-JUMP_VEL);
                        next_y     = (y_try < CEIL_S) ? CEIL_Y : y_try[Y_WIDTH-1:0];
                        next_jumps = J_WIDTH'(1);
                        next_state = ST_RISE;
                    end else if (floor_s > y_s) begin
                        // Walked off a ledge: falling uses up the ground jump.
                        next_vel   = '0;
                        next_jumps = J_WIDTH'(1);
                        next_state = ST_FALL;
                    end else begin
                        next_y = floor_y;
                    end
                end
                ST_RISE: begin
                    if (can_rejump) begin
                        vel_try    = -JUMP_S;
                        next_jumps = jumps_used + J_WIDTH'(1);
                    end else begin
                        vel_try = vel_s + GRAV_S;
                    end
                    y_try    = y_s + vel_try;
                    next_vel = vel_try[V_WIDTH-1:0];
                    next_y   = y_try[Y_WIDTH-1:0];
                    if (!vel_try[S_WIDTH-1]) begin
                        next_state = ST_FALL;
                    end
                    if (y_try < CEIL_S) begin
                        next_y     = CEIL_Y;
                        next_vel   = '0;
                        next_state = ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (can_rejump) begin
                        vel_try    = -JUMP_S;
                        y_try      = y_s + vel_try;
                        next_jumps = jumps_used + J_WIDTH'(1);
                        next_vel   = vel_try[V_WIDTH-1:0];
                        next_y     = y_try[Y_WIDTH-1:0];
                        next_state = ST_RISE;
                        if (y_try < CEIL_S) begin
                            next_y     = CEIL_Y;
                            next_vel   = '0;
                            next_state = ST_FALL;
                        end
                    end else begin
                        vel_try = vel_s + GRAV_S;
                        if (vel_try > MAXF_S) begin
                            vel_try = MAXF_S;
                        end
                        y_try = y_s + vel_try;
                        if (y_try >= floor_s) begin
                            next_y     = floor_y;
                            next_vel   = '0;
                            next_jumps = '0;
                            next_state = ST_GROUND;
                            land_now   = 1'b1;
                        end else begin
                            next_y   = y_try[Y_WIDTH-1:0];
                            next_vel = vel_try[V_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    next_state = ST_GROUND;
                end
            endcase
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        state_out = state;
        on_ground = (state == ST_GROUND);
    end

endmodule

// File: tb/tb_snoopy_vertical_physics.sv
// Directed bench for snoopy_vertical_physics: default instance plus a second
// instance with a low ceiling, both sharing the same stimulus.
module tb_snoopy_vertical_physics;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       jump_in;
    logic [6:0] floor_y;

    logic [6:0] snoopy_y;
    logic [5:0] vel_y;
    logic [1:0] state_out;
    logic [1:0] jumps_used;
    logic       on_ground;
    logic       landed;

    logic [6:0] c_y;
    logic [5:0] c_vel;
    logic [1:0] c_state;
    logic [1:0] c_jumps;
    logic       c_on_ground;
    logic       c_landed;

    int n_checks = 0;
    int n_fail   = 0;

    snoopy_vertical_physics u_dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .jump_in    (jump_in),
        .floor_y    (floor_y),
        .snoopy_y   (snoopy_y),
        .vel_y      (vel_y),
        .state_out  (state_out),
        .jumps_used (jumps_used),
        .on_ground  (on_ground),
        .landed     (landed)
    );

    snoopy_vertical_physics #(.CEILING_Y(90)) u_ceil (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .jump_in    (jump_in),
        .floor_y    (floor_y),
        .snoopy_y   (c_y),
        .vel_y      (c_vel),
        .state_out  (c_state),
        .jumps_used (c_jumps),
        .on_ground  (c_on_ground),
        .landed     (c_landed)
    );

    // Clock and reset
    always #5 clock = ~clock;

    task automatic apply_reset();
        reset      = 1'b0;
        frame_tick = 1'b0;
        jump_in    = 1'b0;
        floor_y    = 7'd100;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Driver tasks: inputs change on the falling edge, outputs are read there too.
    task automatic do_tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic press_jump();
        @(negedge clock);
        jump_in = 1'b1;
        @(negedge clock);
        jump_in = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (snoopy_y !== 7'd100) begin n_fail++; $display("FAIL reset_y: got %0d want 100", snoopy_y); end
        n_checks++; if (vel_y !== 6'd0) begin n_fail++; $display("FAIL reset_vel: got %0d want 0", $signed(vel_y)); end
        n_checks++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_out); end
        n_checks++; if (jumps_used !== 2'd0) begin n_fail++; $display("FAIL reset_jumps: got %0d want 0", jumps_used); end
        n_checks++; if (on_ground !== 1'b1) begin n_fail++; $display("FAIL reset_on_ground: got %0b want 1", on_ground); end
        n_checks++; if (landed !== 1'b0) begin n_fail++; $display("FAIL reset_landed: got %0b want 0", landed); end
        n_checks++; if (c_y !== 7'd100) begin n_fail++; $display("FAIL reset_ceil_y: got %0d want 100", c_y); end
    endtask

    task automatic test_basic_jump();
        int exp_y[17]   = '{92, 85, 79, 74, 70, 67, 65, 64, 64, 65, 67, 70, 74, 79, 85, 92, 100};
        int exp_vel[17] = '{-8, -7, -6, -5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 7, 0};
        int exp_st;
        apply_reset();
        press_jump();
        n_checks++; if (snoopy_y !== 7'd100) begin n_fail++; $display("FAIL hold_no_tick_y: got %0d want 100", snoopy_y); end
        n_checks++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL hold_no_tick_state: got %0d want 0", state_out); end
        for (int i = 0; i < 17; i++) begin
            do_tick();
            exp_st = (i < 8) ? 1 : ((i < 16) ? 2 : 0);
            n_checks++; if (snoopy_y !== 7'(exp_y[i])) begin n_fail++; $display("FAIL basic_y tick %0d: got %0d want %0d", i + 1, snoopy_y, exp_y[i]); end
            n_checks++; if ($signed(vel_y) !== 6'(exp_vel[i])) begin n_fail++; $display("FAIL basic_vel tick %0d: got %0d want %0d", i + 1, $signed(vel_y), exp_vel[i]); end
            n_checks++; if (state_out !== 2'(exp_st)) begin n_fail++; $display("FAIL basic_state tick %0d: got %0d want %0d", i + 1, state_out, exp_st); end
            n_checks++; if (landed !== (i == 16)) begin n_fail++; $display("FAIL basic_landed tick %0d: got %0b want %0b", i + 1, landed, (i == 16)); end
            n_checks++; if (jumps_used !== ((i == 16) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL basic_jumps tick %0d: got %0d", i + 1, jumps_used); end
        end
        @(negedge clock);
        n_checks++; if (landed !== 1'b0) begin n_fail++; $display("FAIL basic_landed_width: got %0b want 0", landed); end
        n_checks++; if (on_ground !== 1'b1) begin n_fail++; $display("FAIL basic_on_ground: got %0b want 1", on_ground); end
    endtask

    task automatic test_double_jump();
        apply_reset();
        press_jump();
        do_tick();
        do_tick();
        n_checks++; if (snoopy_y !== 7'd85) begin n_fail++; $display("FAIL dbl_pre_y: got %0d want 85", snoopy_y); end
        press_jump();
        do_tick();
        n_checks++; if (snoopy_y !== 7'd77) begin n_fail++; $display("FAIL dbl_y: got %0d want 77", snoopy_y); end
        n_checks++; if ($signed(vel_y) !== -6'sd8) begin n_fail++; $display("FAIL dbl_vel: got %0d want -8", $signed(vel_y)); end
        n_checks++; if (jumps_used !== 2'd2) begin n_fail++; $display("FAIL dbl_jumps: got %0d want 2", jumps_used); end
        n_checks++; if (state_out !== 2'b01) begin n_fail++; $display("FAIL dbl_state: got %0d want 1", state_out); end
        press_jump();
        do_tick();
        n_checks++; if ($signed(vel_y) !== -6'sd7) begin n_fail++; $display("FAIL third_vel: got %0d want -7", $signed(vel_y)); end
        n_checks++; if (snoopy_y !== 7'd70) begin n_fail++; $display("FAIL third_y: got %0d want 70", snoopy_y); end
        do_tick();
        n_checks++; if ($signed(vel_y) !== -6'sd6) begin n_fail++; $display("FAIL third_cont_vel: got %0d want -6", $signed(vel_y)); end
        n_checks++; if (jumps_used !== 2'd2) begin n_fail++; $display("FAIL third_jumps: got %0d want 2", jumps_used); end
    endtask

    task automatic test_held_jump();
        apply_reset();
        @(negedge clock);
        jump_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            do_tick();
            if (i == 1) begin
                n_checks++; if ($signed(vel_y) !== -6'sd7) begin n_fail++; $display("FAIL held_vel tick2: got %0d want -7", $signed(vel_y)); end
            end
        end
        n_checks++; if (snoopy_y !== 7'd100) begin n_fail++; $display("FAIL held_y: got %0d want 100", snoopy_y); end
        n_checks++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL held_state: got %0d want 0", state_out); end
        n_checks++; if (jumps_used !== 2'd0) begin n_fail++; $display("FAIL held_jumps: got %0d want 0", jumps_used); end
        jump_in = 1'b0;
        // Edge three cycles ahead of the tick is buffered until the tick.
        press_jump();
        repeat (2) @(negedge clock);
        n_checks++; if (snoopy_y !== 7'd100) begin n_fail++; $display("FAIL early_edge_wait_y: got %0d want 100", snoopy_y); end
        do_tick();
        n_checks++; if (snoopy_y !== 7'd92) begin n_fail++; $display("FAIL early_edge_y: got %0d want 92", snoopy_y); end
        do_tick();
        n_checks++; if ($signed(vel_y) !== -6'sd7) begin n_fail++; $display("FAIL early_edge_once: got %0d want -7", $signed(vel_y)); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        @(negedge clock);
        jump_in    = 1'b1;
        frame_tick = 1'b1;
        @(negedge clock);
        jump_in    = 1'b0;
        frame_tick = 1'b0;
        n_checks++; if (snoopy_y !== 7'd92) begin n_fail++; $display("FAIL same_cycle_y: got %0d want 92", snoopy_y); end
        n_checks++; if (state_out !== 2'b01) begin n_fail++; $display("FAIL same_cycle_state: got %0d want 1", state_out); end
        do_tick();
        n_checks++; if ($signed(vel_y) !== -6'sd7) begin n_fail++; $display("FAIL same_cycle_next_vel: got %0d want -7", $signed(vel_y)); end
        n_checks++; if (jumps_used !== 2'd1) begin n_fail++; $display("FAIL same_cycle_jumps: got %0d want 1", jumps_used); end
    endtask

    task automatic test_ceiling();
        apply_reset();
        press_jump();
        do_tick();
        n_checks++; if (c_y !== 7'd92) begin n_fail++; $display("FAIL ceil_jump_y: got %0d want 92", c_y); end
        n_checks++; if (c_state !== 2'b01) begin n_fail++; $display("FAIL ceil_jump_state: got %0d want 1", c_state); end
        do_tick();
        n_checks++; if (c_y !== 7'd90) begin n_fail++; $display("FAIL ceil_bump_y: got %0d want 90", c_y); end
        n_checks++; if (c_vel !== 6'd0) begin n_fail++; $display("FAIL ceil_bump_vel: got %0d want 0", $signed(c_vel)); end
        n_checks++; if (c_state !== 2'b10) begin n_fail++; $display("FAIL ceil_bump_state: got %0d want 2", c_state); end
        n_checks++; if (c_landed !== 1'b0) begin n_fail++; $display("FAIL ceil_landed: got %0b want 0", c_landed); end
    endtask

    task automatic test_ledge_air_jumps();
        apply_reset();
        floor_y = 7'd127;
        do_tick();
        n_checks++; if (state_out !== 2'b10) begin n_fail++; $display("FAIL ledge_state: got %0d want 2", state_out); end
        n_checks++; if (jumps_used !== 2'd1) begin n_fail++; $display("FAIL ledge_jumps: got %0d want 1", jumps_used); end
        n_checks++; if (snoopy_y !== 7'd100 || vel_y !== 6'd0) begin n_fail++; $display("FAIL ledge_pos: got y %0d v %0d want y 100 v 0", snoopy_y, $signed(vel_y)); end
        press_jump();
        do_tick();
        n_checks++; if (snoopy_y !== 7'd92 || $signed(vel_y) !== -6'sd8) begin n_fail++; $display("FAIL air_jump: got y %0d v %0d want y 92 v -8", snoopy_y, $signed(vel_y)); end
        n_checks++; if (jumps_used !== 2'd2 || state_out !== 2'b01) begin n_fail++; $display("FAIL air_jump_state: got j %0d s %0d want j 2 s 1", jumps_used, state_out); end
        press_jump();
        do_tick();
        n_checks++; if (snoopy_y !== 7'd85 || $signed(vel_y) !== -6'sd7) begin n_fail++; $display("FAIL refused_jump: got y %0d v %0d want y 85 v -7", snoopy_y, $signed(vel_y)); end
        repeat (17) do_tick();
        n_checks++; if (snoopy_y !== 7'd119 || $signed(vel_y) !== 6'sd10 || state_out !== 2'b10) begin n_fail++; $display("FAIL prelanding: got y %0d v %0d s %0d want y 119 v 10 s 2", snoopy_y, $signed(vel_y), state_out); end
        // Ineligible jump on the landing tick: landing wins, request is dropped.
        press_jump();
        do_tick();
        n_checks++; if (snoopy_y !== 7'd127 || vel_y !== 6'd0) begin n_fail++; $display("FAIL land_pos: got y %0d v %0d want y 127 v 0", snoopy_y, $signed(vel_y)); end
        n_checks++; if (landed !== 1'b1 || state_out !== 2'b00 || jumps_used !== 2'd0) begin n_fail++; $display("FAIL land_flags: got l %0b s %0d j %0d want l 1 s 0 j 0", landed, state_out, jumps_used); end
        do_tick();
        n_checks++; if (snoopy_y !== 7'd127 || state_out !== 2'b00 || landed !== 1'b0) begin n_fail++; $display("FAIL land_discard: got y %0d s %0d l %0b want y 127 s 0 l 0", snoopy_y, state_out, landed); end
        press_jump();
        do_tick();
        n_checks++; if (snoopy_y !== 7'd119 || $signed(vel_y) !== -6'sd8 || jumps_used !== 2'd1) begin n_fail++; $display("FAIL rejump_ground: got y %0d v %0d j %0d want y 119 v -8 j 1", snoopy_y, $signed(vel_y), jumps_used); end
    endtask

    task automatic test_terminal_velocity();
        int exp_y[14]   = '{31, 33, 36, 40, 45, 51, 58, 66, 75, 85, 95, 105, 115, 125};
        int exp_vel[14] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10, 10};
        apply_reset();
        floor_y = 7'd30;
        do_tick();
        n_checks++; if (snoopy_y !== 7'd30 || state_out !== 2'b00) begin n_fail++; $display("FAIL floor_track: got y %0d s %0d want y 30 s 0", snoopy_y, state_out); end
        floor_y = 7'd127;
        do_tick();
        n_checks++; if (state_out !== 2'b10 || snoopy_y !== 7'd30) begin n_fail++; $display("FAIL walkoff: got y %0d s %0d want y 30 s 2", snoopy_y, state_out); end
        for (int i = 0; i < 14; i++) begin
            do_tick();
            n_checks++; if (snoopy_y !== 7'(exp_y[i]) || $signed(vel_y) !== 6'(exp_vel[i])) begin n_fail++; $display("FAIL fall tick %0d: got y %0d v %0d want y %0d v %0d", i + 1, snoopy_y, $signed(vel_y), exp_y[i], exp_vel[i]); end
        end
        do_tick();
        n_checks++; if (snoopy_y !== 7'd127 || landed !== 1'b1 || state_out !== 2'b00) begin n_fail++; $display("FAIL fall_land: got y %0d l %0b s %0d want y 127 l 1 s 0", snoopy_y, landed, state_out); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        press_jump();
        repeat (5) do_tick();
        n_checks++; if (snoopy_y !== 7'd70 || $signed(vel_y) !== -6'sd4) begin n_fail++; $display("FAIL midrise: got y %0d v %0d want y 70 v -4", snoopy_y, $signed(vel_y)); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (snoopy_y !== 7'd100 || vel_y !== 6'd0) begin n_fail++; $display("FAIL async_pos: got y %0d v %0d want y 100 v 0", snoopy_y, $signed(vel_y)); end
        n_checks++; if (state_out !== 2'b00 || jumps_used !== 2'd0 || on_ground !== 1'b1 || landed !== 1'b0) begin n_fail++; $display("FAIL async_flags: got s %0d j %0d g %0b l %0b", state_out, jumps_used, on_ground, landed); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (landed !== 1'b0 || snoopy_y !== 7'd100) begin n_fail++; $display("FAIL async_after: got l %0b y %0d want l 0 y 100", landed, snoopy_y); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_basic_jump();
        test_double_jump();
        test_held_jump();
        test_same_cycle();
        test_ceiling();
        test_ledge_air_jumps();
        test_terminal_velocity();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snoopy_vertical_physics.md
Name: snoopy_vertical_physics

Overview:
Velocity-based vertical motion controller for Snoopy, the parametrised successor to the fixed-step vertical FSM. It tracks a signed vertical velocity and applies gravity once per frame tick. It supports N-jump chaining, edge-triggered jump requests, a ceiling clamp with head-bump, terminal fall velocity, and a runtime floor height for platforms and ledges. It sits between the input synchroniser and the sprite/collision renderer, and its output drives the sprite Y coordinate.

Parameters:
Y_WIDTH, 7, width of position and floor values (unsigned screen Y, down = positive)
V_WIDTH, 6, width of signed velocity
GROUND_Y, 100, reset position
CEILING_Y, 0, minimum allowed Y
JUMP_VEL, 8, upward speed magnitude applied on each jump
GRAVITY, 1, velocity increment per frame tick
MAX_FALL_VEL, 10, terminal downward velocity
MAX_JUMPS, 2, jumps allowed before landing, counting the ground jump

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle physics update strobe
jump_in  in  1  jump button, level, already synchronised
floor_y  in  Y_WIDTH  current floor height under Snoopy
snoopy_y  out  Y_WIDTH  current Y position
vel_y  out  V_WIDTH  signed velocity, negative = upward
state_out  out  2  00 GROUND, 01 RISE, 10 FALL
jumps_used  out  $clog2(MAX_JUMPS+1)  jumps consumed since last landing
on_ground  out  1  high in GROUND
landed  out  1  one-cycle pulse on landing

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is asynchronous and active-low.
- Reset values: snoopy_y=GROUND_Y, vel_y=0, state GROUND, jumps_used=0, on_ground=1, landed=0, jump request latch=0, previous-jump register=0.
- Jump request:
  - A rising edge of jump_in, detected on any clock, sets jump_req.
  - jump_req is cleared on every frame_tick, whether or not the request is consumed. Only one request is buffered.
  - An edge arriving in the same cycle as frame_tick is consumed by that tick.
  - A held jump_in never retriggers.
- Updates happen only on frame_tick; all registers hold otherwise. Arithmetic uses Y_WIDTH+2-bit signed intermediates. New position = y + new velocity (semi-implicit update).
- GROUND state:
  - If jump_req: vel=-JUMP_VEL, y=max(y-JUMP_VEL, CEILING_Y), jumps_used=1, go to RISE.
  - Else, if floor_y > y (ledge walk-off): vel=0, jumps_used=1, go to FALL.
  - Else: y=floor_y (tracks a rising floor).
- RISE state:
  - If jump_req and jumps_used<MAX_JUMPS: vel=-JUMP_VEL, jumps_used+1, y-=JUMP_VEL.
  - Else: vel+=GRAVITY.
  - If the new velocity is >=0, go to FALL.
  - If y+vel<CEILING_Y: y=CEILING_Y, vel=0, go to FALL (head-bump).
- FALL state:
  - If jump_req and jumps_used<MAX_JUMPS: same as the RISE re-jump, go to RISE.
  - Else: vel=min(vel+GRAVITY, MAX_FALL_VEL) and y_next=y+vel.
  - If y_next>=floor_y: y=floor_y, vel=0, jumps_used=0, go to GROUND, assert landed for exactly one clock.
- Limits and ties:
  - A jump request with jumps_used==MAX_JUMPS is discarded.
  - Landing takes priority over a simultaneous ineligible jump.
  - On the tick that lands, a jump request is discarded; the next edge jumps from GROUND.
- Outputs are registered; zero latency from state to outputs.
- Reset asserted mid-air returns to the reset values immediately, with no landed pulse.

Test Plan:
- Reset, jump edge, ticks with defaults -> y 92,85,79,74,70,67,65,64,64 (FALL at tick 9), then 65,67,70,74,79,85,92,100. landed pulses on tick 17; jumps_used returns to 0.
- Jump, then a second edge at tick 3 (y=85) -> vel=-8, y=77, jumps_used=2. A third edge is ignored, and vel continues -6.
- jump_in held high across 30 ticks after the first edge -> single jump only. An edge placed 3 cycles before a tick is consumed by that tick.
- CEILING_Y=90: jump -> y=92, next tick y=90, vel=0, state FALL.
- Idle at 100, floor_y changes to 127 -> FALL with jumps_used=1. vel saturates at 10. Lands at y=127 with a landed pulse. One air jump is allowed, a second is refused.
- Reset pulsed low mid-rise (y=70) between clock edges -> outputs go to reset values asynchronously, with no landed pulse.
